dmem_arbiter: RTL and testbench

- Shares the single data memory port between two requesters.
- Port C is the core load/store stage. Port D is the debug/program-loader port.
- One access per cycle. Core has priority on conflict, with a starvation limit that guarantees D progress.
- D may lock the memory for back-to-back transfers, e.g. bulk program load.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single data memory port: core (C) has priority,
// debug (D) is protected by a starvation counter and can lock the port for bursts.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  // Handshake: a requester raises req with stable fields and holds them until gnt;
  // gnt is combinational and marks the cycle the access is issued to memory.
  // Reads return rdata one cycle later, flagged by a single-cycle rvalid pulse.
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [2:0]    c_whb,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_whb,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rw,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_whb,
  input  logic [DW-1:0] mem_rdata,
  output logic          locked
);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        state_q;
  logic [3:0]    starve_cnt_q;
  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          c_rvalid_q;
  logic          d_rvalid_q;
  logic          c_grant;
  logic          d_grant;

  always_comb begin
    c_grant = 1'b0;
    d_grant = 1'b0;
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        d_grant = d_req;
      end else if (c_req && d_req) begin
        d_grant = (starve_cnt_q >= LIMIT);
        c_grant = !(starve_cnt_q >= LIMIT);
      end else begin
        c_grant = c_req;
        d_grant = d_req;
      end
    end
  end

  // Idle bus parks on a harmless read with the default word size code.
  always_comb begin
    mem_addr  = '0;
    mem_rw    = 1'b0;
    mem_wdata = '0;
    mem_whb   = 3'b010;
    if (c_grant) begin
      mem_addr  = c_addr;
      mem_rw    = c_we;
      mem_wdata = c_wdata;
      mem_whb   = c_whb;
    end else if (d_grant) begin
      mem_addr  = d_addr;
      mem_rw    = d_we;
      mem_wdata = d_wdata;
      mem_whb   = d_whb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB;
      starve_cnt_q <= '0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
      c_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      c_rvalid_q <= c_grant && !c_we;
      d_rvalid_q <= d_grant && !d_we;
      if (c_grant && !c_we) c_rdata_q <= mem_rdata;
      if (d_grant && !d_we) d_rdata_q <= mem_rdata;

      case (state_q)
        ST_ARB: begin
          // Counts only cycles where D was waiting and lost to C.
          if (c_grant && d_req) begin
            starve_cnt_q <= (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_q <= '0;
          end
          if (d_grant && d_lock) state_q <= ST_LOCKED;
        end
        ST_LOCKED: begin
          starve_cnt_q <= '0;
          if (!d_lock) state_q <= ST_ARB;
        end
        default: begin
          state_q      <= ST_ARB;
          starve_cnt_q <= '0;
        end
      endcase
    end
  end

  assign c_gnt    = c_grant;
  assign d_gnt    = d_grant;
  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign locked   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a limit-4 instance with a word memory behind it, plus a
// limit-0 instance sharing the same request stimulus.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0]  c_whb, d_whb;

  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_rw, locked;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_whb;

  logic        c_gnt0, c_rvalid0, d_gnt0, d_rvalid0, mem_rw0, locked0;
  logic [31:0] c_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [2:0]  mem_whb0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        c_pend   = 1'b0;
  logic        d_pend   = 1'b0;
  logic [31:0] c_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4), .AW(32), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_whb(c_whb),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_whb(d_whb),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_whb(mem_whb),
    .mem_rdata(mem_rdata), .locked(locked)
  );

  dmem_arbiter #(.STARVE_LIMIT(0), .AW(32), .DW(32)) u_dut0 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_whb(c_whb),
    .c_gnt(c_gnt0), .c_rvalid(c_rvalid0), .c_rdata(c_rdata0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_whb(d_whb),
    .d_lock(d_lock), .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .mem_addr(mem_addr0), .mem_rw(mem_rw0), .mem_wdata(mem_wdata0), .mem_whb(mem_whb0),
    .mem_rdata(mem_rdata0), .locked(locked0)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'h5A5A_0000 | 32'(i));
  endfunction

  // Memory device: loaded once, then written only through the arbiter's port.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_rw) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata  = mem[mem_addr[7:2]];
  assign mem_rdata0 = ~mem_addr0;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_c(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] whb);
    c_req = req; c_we = we; c_addr = addr; c_wdata = wdata; c_whb = whb;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] whb, input logic lock);
    d_req = req; d_we = we; d_addr = addr; d_wdata = wdata; d_whb = whb; d_lock = lock;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one cycle of the limit-4 instance at the falling edge against the
  // expected grants; read results are queued for the following cycle.
  task automatic cyc(input logic ecg, input logic edg);
    logic [31:0] ea, ed;
    logic [2:0]  eh;
    logic        erw;
    @(negedge clk);
    check("c_gnt", c_gnt, ecg);
    check("d_gnt", d_gnt, edg);
    check("one_gnt", c_gnt & d_gnt, 0);
    check("c_rvalid", c_rvalid, c_pend);
    check("d_rvalid", d_rvalid, d_pend);
    if (c_pend) check("c_rdata", c_rdata, (c_exp_q.size() > 0) ? c_exp_q.pop_front() : 32'hx);
    if (d_pend) check("d_rdata", d_rdata, (d_exp_q.size() > 0) ? d_exp_q.pop_front() : 32'hx);
    ea = 0; ed = 0; eh = 3'b010; erw = 1'b0;
    if (ecg) begin
      ea = c_addr; ed = c_wdata; eh = c_whb; erw = c_we;
    end else if (edg) begin
      ea = d_addr; ed = d_wdata; eh = d_whb; erw = d_we;
    end
    check("mem_rw", mem_rw, erw);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    check("mem_whb", mem_whb, eh);
    c_pend = ecg && !c_we;
    d_pend = edg && !d_we;
    if (c_pend) c_exp_q.push_back(ref_mem[c_addr[7:2]]);
    if (d_pend) d_exp_q.push_back(ref_mem[d_addr[7:2]]);
    if (ecg && c_we) ref_mem[c_addr[7:2]] = c_wdata;
    if (edg && d_we) ref_mem[d_addr[7:2]] = d_wdata;
  endtask

  task automatic idle_inputs();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    set_d(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc(1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    rst = 1'b1;
    idle_inputs();
    step();
    do_reset();
    cyc(1'b0, 1'b0);
    check("rst_locked", locked, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    step();

    // Core read alone: granted at once, data one cycle later.
    set_c(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    cyc(1'b1, 1'b0);
    step();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    cyc(1'b0, 1'b0);
    check("c_rdata_beef", c_rdata, 32'hDEAD_BEEF);
    step();

    // Continuous conflict: limit 4 gives C,C,C,C,D; limit 0 gives D every cycle.
    do_reset();
    set_c(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    set_d(1'b1, 1'b0, 32'h24, 32'h0, 3'b010, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc((k % 5) != 4, (k % 5) == 4);
      check("lim0_d_gnt", d_gnt0, 1);
      check("lim0_c_gnt", c_gnt0, 0);
      step();
    end
    set_d(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    cyc(1'b1, 1'b0);
    check("lim0_c_only", c_gnt0, 1);
    step();
    idle_inputs();
    cyc(1'b0, 1'b0);
    step();

    // Locked burst of four D writes while the core waits.
    do_reset();
    set_d(1'b1, 1'b1, 32'h20, 32'hAA, 3'b000, 1'b1);
    cyc(1'b0, 1'b1);
    step();
    for (int i = 1; i < 4; i++) begin
      set_c(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
      set_d(1'b1, 1'b1, 32'h20 + 32'(4 * i), 32'hAA + 32'(i), 3'b000, 1'b1);
      cyc(1'b0, 1'b1);
      check("burst_locked", locked, 1);
      step();
    end
    set_d(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    cyc(1'b0, 1'b0);
    check("unlock_cycle_locked", locked, 1);
    step();
    cyc(1'b1, 1'b0);
    check("after_unlock", locked, 0);
    step();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    set_d(1'b1, 1'b0, 32'h2C, 32'h0, 3'b010, 1'b0);
    cyc(1'b0, 1'b1);
    step();
    set_d(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0);
    cyc(1'b0, 1'b1);
    check("readback_2c", d_rdata, 32'hAD);
    step();
    idle_inputs();
    cyc(1'b0, 1'b0);
    check("readback_20", d_rdata, 32'hAA);
    step();

    // C read in N, D write in N+1: C's rvalid is undisturbed.
    set_c(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    cyc(1'b1, 1'b0);
    step();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    set_d(1'b1, 1'b1, 32'h30, 32'h1234, 3'b011, 1'b0);
    cyc(1'b0, 1'b1);
    step();
    idle_inputs();
    cyc(1'b0, 1'b0);
    step();

    // Reset while locked with a pending D write: no write, state cleared.
    set_d(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
    cyc(1'b0, 1'b1);
    step();
    rst = 1'b1;
    set_d(1'b1, 1'b1, 32'h14, 32'h5555, 3'b010, 1'b1);
    cyc(1'b0, 1'b0);
    check("pre_rst_locked", locked, 1);
    step();
    rst = 1'b0;
    idle_inputs();
    cyc(1'b0, 1'b0);
    check("post_rst_locked", locked, 0);
    check("post_rst_c_rdata", c_rdata, 0);
    check("post_rst_d_rdata", d_rdata, 0);
    step();
    set_c(1'b1, 1'b0, 32'h14, 32'h0, 3'b010);
    set_d(1'b1, 1'b0, 32'h18, 32'h0, 3'b010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(k < 4, k == 4);
      step();
    end
    idle_inputs();
    cyc(1'b0, 1'b0);
    check("no_write_in_rst", c_rdata, 32'h5A5A_0005);
    step();
    cyc(1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
